// File: rtl/rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter
//
// Round-robin arbiter sharing one downstream resource among N requesters.
// Priority rotates after every ownership, so no requester starves. An optional
// hold limit ends an ownership whose request stays asserted too long.
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   synchronous reset, active-low
//   req          in   N   request vector, bit i = requester i
//   grant        out  N   one-hot grant, all-zero when there is no owner
//   grant_idx    out  IW  binary index of the owner; 0 when grant_valid=0
//   grant_valid  out  1   high while any grant bit is set
//   dbg_state    out  1   FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr      out  IW  index with highest priority at the next arbitration
//
// Request/grant protocol: a requester holds its req bit high for as long as
// it wants the resource. It owns the resource in every cycle where its grant
// bit is high. Dropping req ends the ownership at the next edge. Every
// ownership is followed by exactly one cycle with grant=0. Requests seen
// while someone else owns the resource are not remembered; they are only
// looked at again in the idle cycle.
//
// Parameters
//   N         number of requesters (2..32)
//   IW        width of grant_idx, equal to $clog2(N)
//   MAX_HOLD  max consecutive grant cycles per ownership, 0 = unlimited
// -----------------------------------------------------------------------------
module rr_req_arbiter #(
    parameter int N        = 8,
    parameter int IW       = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid,
    output logic          dbg_state,
    output logic [IW-1:0] dbg_ptr
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Hold counter must be able to represent MAX_HOLD itself.
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic          HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q,  state_d;
    logic [N-1:0]    grant_q,  grant_d;
    logic [IW-1:0]   idx_q,    idx_d;
    logic            valid_q,  valid_d;
    logic [IW-1:0]   ptr_q,    ptr_d;
    logic [HW-1:0]   hold_q,   hold_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Index of the lowest set bit of v; 0 when v is empty.
    function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    // Successor modulo N; handles non-power-of-two N.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        logic [IW-1:0] r;
        if (i == LAST_IDX) begin
            r = '0;
        end else begin
            r = i + IW'(1);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Rotating winner search
    //
    // The search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 is split into two
    // halves: the bits at or above ptr are searched first, and only if none
    // of them is set does the lowest set bit of the whole vector win (which
    // is then necessarily below ptr).
    // -------------------------------------------------------------------------
    logic [N-1:0]  upper_mask;
    logic [N-1:0]  upper_req;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;

    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (IW'(i) >= ptr_q);
        end
    end

    assign upper_req = req & upper_mask;

    always_comb begin
        win_idx = '0;
        if (|upper_req) begin
            win_idx = lowest_idx(upper_req);
        end else begin
            win_idx = lowest_idx(req);
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

    // -------------------------------------------------------------------------
    // Ownership end conditions
    // -------------------------------------------------------------------------
    logic owner_req;
    logic hold_expired;
    logic release_now;

    // The grant register is one-hot, so masking req with it picks the
    // owner's request bit without indexing by grant_idx.
    assign owner_req    = |(req & grant_q);
    assign hold_expired = HOLD_EN && (hold_q == HOLD_MAX);
    assign release_now  = !owner_req || hold_expired;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                if (|req) begin
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    hold_d  = HW'(1);
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (release_now) begin
                    // Release and preemption are handled identically: the
                    // owner drops to lowest priority for the next round.
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = next_idx(idx_q);
                    state_d = ST_IDLE;
                end else if (hold_q != HOLD_MAX) begin
                    // Saturates at MAX_HOLD; with no limit the value is unused.
                    hold_d = hold_q + HW'(1);
                end
            end

            default: begin
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -------------------------------------------------------------------------
    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign dbg_state   = state_q;
    assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_req_arbiter
//
// Directed bench for rr_req_arbiter (N=8, MAX_HOLD=4). Inputs change 1 time
// unit after each rising edge; outputs are checked at that same point, i.e.
// they show the result of the edge just taken. A per-cycle monitor on the
// falling edge checks the grant encoding and the bounded-wait property.
// -----------------------------------------------------------------------------
module tb_rr_req_arbiter;

  localparam int N          = 8;
  localparam int IW         = 3;
  localparam int MAX_HOLD   = 4;
  localparam int WAIT_BOUND = N * (MAX_HOLD + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '1;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          dbg_state;
  logic [IW-1:0] dbg_ptr;

  always #5 clk = ~clk;

  rr_req_arbiter #(
    .N        (N),
    .IW       (IW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // ---------------------------------------------------------------------------
  // Driver / check tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] eg,
                           input logic [IW-1:0] ei, input logic ev);
    checks++;
    assert (grant === eg) else begin
      failures++;
      $error("FAIL %s grant got=%h exp=%h", tag, grant, eg);
    end
    checks++;
    assert (grant_idx === ei) else begin
      failures++;
      $error("FAIL %s grant_idx got=%0d exp=%0d", tag, grant_idx, ei);
    end
    checks++;
    assert (grant_valid === ev) else begin
      failures++;
      $error("FAIL %s grant_valid got=%b exp=%b", tag, grant_valid, ev);
    end
  endtask

  task automatic check_ptr(input string tag, input logic [IW-1:0] ep);
    checks++;
    assert (dbg_ptr === ep) else begin
      failures++;
      $error("FAIL %s ptr got=%0d exp=%0d", tag, dbg_ptr, ep);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle monitor
  // ---------------------------------------------------------------------------
  int wait_cnt [N];
  logic [N-1:0] mon_one;
  logic [N-1:0] mon_exp;

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($onehot0(grant)) else begin
        failures++;
        $error("FAIL inv_onehot grant got=%h exp=onehot0", grant);
      end
      checks++;
      assert (grant_valid === (|grant)) else begin
        failures++;
        $error("FAIL inv_valid grant_valid got=%b exp=%b", grant_valid, |grant);
      end
      mon_one = 1;
      mon_exp = grant_valid ? (mon_one << grant_idx) : '0;
      checks++;
      assert (grant === mon_exp && (grant_valid || grant_idx == 0)) else begin
        failures++;
        $error("FAIL inv_idx grant got=%h idx=%0d exp=%h", grant, grant_idx, mon_exp);
      end
      for (int i = 0; i < N; i++) begin
        if (!rst_n || !req[i] || grant[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        checks++;
        assert (wait_cnt[i] <= WAIT_BOUND) else begin
          failures++;
          $error("FAIL inv_wait req%0d got=%0d exp<=%0d", i, wait_cnt[i], WAIT_BOUND);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [N-1:0] one;
  logic [N-1:0] bits;
  int           owner;

  initial begin
    one = 1;

    // Reset held with every request active.
    rst_n = 1'b0;
    req   = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      mon_en = 1'b1;
      check_out("reset", 8'h00, 3'd0, 1'b0);
      check_ptr("reset", 3'd0);
    end

    // Single request, then release.
    rst_n = 1'b1;
    req   = 8'h10;
    step();
    check_out("single_grant", 8'h10, 3'd4, 1'b1);
    req = 8'h00;
    step();
    check_out("single_release", 8'h00, 3'd0, 1'b0);
    check_ptr("single_release", 3'd5);
    step();
    check_out("idle_no_req", 8'h00, 3'd0, 1'b0);

    // Rotation with everyone requesting; each owner drops after 2 cycles.
    rst_n = 1'b0;
    step();
    check_ptr("rot_reset", 3'd0);
    rst_n = 1'b1;
    req   = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      owner = k % 8;
      bits  = one << owner;
      step();
      check_out("rot_grant", bits, IW'(owner), 1'b1);
      step();
      check_out("rot_hold", bits, IW'(owner), 1'b1);
      req = 8'hFF & ~bits;
      step();
      check_out("rot_idle", 8'h00, 3'd0, 1'b0);
      check_ptr("rot_idle", IW'((owner + 1) % 8));
      req = 8'hFF;
    end

    // Preemption at MAX_HOLD=4 with req=03 held.
    rst_n = 1'b0;
    req   = 8'h03;
    step();
    check_out("pre_reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_out("pre_own0", 8'h01, 3'd0, 1'b1);
    end
    step();
    check_out("pre_idle0", 8'h00, 3'd0, 1'b0);
    check_ptr("pre_idle0", 3'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check_out("pre_own1", 8'h02, 3'd1, 1'b1);
    end
    step();
    check_out("pre_idle1", 8'h00, 3'd0, 1'b0);
    check_ptr("pre_idle1", 3'd2);
    step();
    check_out("pre_again0", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    step();
    check_out("pre_release", 8'h00, 3'd0, 1'b0);
    check_ptr("pre_release", 3'd1);

    // Wrap from 7 to 0 and non-owner requests during a grant.
    req = 8'h80;
    step();
    check_out("wrap_own7", 8'h80, 3'd7, 1'b1);
    req = 8'h00;
    step();
    check_out("wrap_idle", 8'h00, 3'd0, 1'b0);
    check_ptr("wrap_ptr", 3'd0);
    req = 8'h81;
    step();
    check_out("wrap_win0", 8'h01, 3'd0, 1'b1);
    req = 8'h83;
    step();
    check_out("nonowner_a", 8'h01, 3'd0, 1'b1);
    step();
    check_out("nonowner_b", 8'h01, 3'd0, 1'b1);
    req = 8'h82;
    step();
    check_out("nonowner_rel", 8'h00, 3'd0, 1'b0);
    check_ptr("nonowner_rel", 3'd1);
    step();
    check_out("nonowner_next", 8'h02, 3'd1, 1'b1);
    req = 8'h00;
    step();
    check_out("nonowner_idle", 8'h00, 3'd0, 1'b0);
    check_ptr("nonowner_idle", 3'd2);

    // Reset in the middle of a grant with ptr=5, owner 5.
    req = 8'h10;
    step();
    check_out("mid_own4", 8'h10, 3'd4, 1'b1);
    req = 8'h00;
    step();
    check_ptr("mid_ptr5", 3'd5);
    req = 8'h20;
    step();
    check_out("mid_own5", 8'h20, 3'd5, 1'b1);
    req   = 8'h21;
    rst_n = 1'b0;
    step();
    check_out("mid_reset", 8'h00, 3'd0, 1'b0);
    check_ptr("mid_reset", 3'd0);
    rst_n = 1'b1;
    step();
    check_out("mid_after", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    step();
    check_out("mid_release", 8'h00, 3'd0, 1'b0);
    check_ptr("mid_release", 3'd1);

    step();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
